ber_checker: RTL and testbench
==============================

BER_CHECKER -- requirements
Module: ber_checker

Interface
REQ-001 Parameter NBT_COUNT_BITS_ERR, default 64: width of the error and total-bit accumulators.
REQ-002 Parameter PRBS_LEN, default 511: PRBS period; sets the delay-line depth and the window length.
REQ-003 Parameter ERR_THR, default 0: maximum errors per locked window for which BER is reported OK.
REQ-004 clk  input  1  system clock, all logic rising-edge.
REQ-005 i_reset  input  1  reset, asynchronous, active-high.
REQ-006 i_enable  input  1  soft enable; low forces IDLE.
REQ-007 i_valid  input  1  symbol-rate strobe; qualifies i_ref_bit and i_rx_bit.
REQ-008 i_ref_bit  input  1  transmitted PRBS reference bit.
REQ-009 i_rx_bit  input  1  sliced received bit for the same branch, I or Q.
REQ-010 o_accum_err  output  NBT_COUNT_BITS_ERR  locked-state error count.
REQ-011 o_accum_tot  output  NBT_COUNT_BITS_ERR  locked-state compared-bit count.
REQ-012 o_sync_done  output  1  high while in LOCKED.
REQ-013 o_ber_ok  output  1  last completed locked window had at most ERR_THR errors.
REQ-014 o_delay_sel  output  clog2(PRBS_LEN)  delay chosen at lock.

Function
REQ-015 Delay line: PRBS_LEN-bit shift register; on each i_valid, i_ref_bit enters tap 0 and older bits shift up one tap; tap d holds the reference from d+1 valids earlier.
REQ-016 States are IDLE, SEARCH and LOCKED.
REQ-017 IDLE: window counter, candidate delay, window error count, best_err and accumulators are cleared; the FSM moves to SEARCH on the first cycle i_enable is high.
REQ-018 SEARCH: candidate delay d starts at 0; each i_valid compares i_rx_bit with tap d and increments the window error count on mismatch.
REQ-019 SEARCH window end occurs after PRBS_LEN valids; if the window error count is below best_err, best_err and best_d are updated (best_err resets to all-ones).
REQ-020 At SEARCH window end with zero errors, the FSM locks immediately with o_delay_sel=d (early lock).
REQ-021 Otherwise d increments; after the window for d=PRBS_LEN-1, the FSM locks with o_delay_sel=best_d.
REQ-022 Lock-entry cycle clears o_accum_err, o_accum_tot and the window counters.
REQ-023 LOCKED: each i_valid increments o_accum_tot and, on mismatch against tap o_delay_sel, increments o_accum_err; outputs update on the cycle after the valid.
REQ-024 Both accumulators saturate at all-ones and never wrap.
REQ-025 LOCKED window: every PRBS_LEN valids, o_ber_ok is set to (window errors <= ERR_THR) and the window error count restarts.
REQ-026 Both events in one cycle: the window-end compare includes the current bit's mismatch.
REQ-027 i_enable low in any state returns the FSM to IDLE on the next edge and clears all outputs; that takes priority over i_valid.
REQ-028 Cycles without i_valid hold all state.

Reset
REQ-029 i_reset high asynchronously clears all outputs to 0, the FSM to IDLE and the delay line to 0; best_err is set to all-ones.
REQ-030 Reset mid-SEARCH or mid-LOCKED discards progress; a fresh search starts after release with i_enable high.

Structure
REQ-031 FSM state encoding and the default PRBS_LEN/ERR_THR constants belong in the shared comm-system package.
REQ-032 One sub-module is natural: sat_counter (parameterized saturating incrementer), instantiated for both accumulators.
REQ-033 The block is instantiated once per branch (I, Q) inside the QPSK system; its outputs feed the register-file accumulator inputs and the sync/BER LEDs.

Verification
REQ-034 PRBS9 reference, rx = ref delayed 38 valids, continuous valid -> early lock after 38*511 valids, o_delay_sel=37, o_sync_done=1, o_accum_err stays 0, o_ber_ok=1 after one more window.
REQ-035 Same setup, invert one rx bit at locked valid #1000 -> o_accum_err=1, o_accum_tot=1000+n, o_ber_ok=0 for that window, then 1 again.
REQ-036 rx = ref delayed 100 with one forced error per window -> full 511-window search, lock at o_delay_sel=99, best_err=1.
REQ-037 NBT_COUNT_BITS_ERR=8, locked with rx inverted -> o_accum_err and o_accum_tot both stick at 255.
REQ-038 i_enable dropped mid-LOCKED, then i_reset pulsed mid-SEARCH -> next edge / immediate: all outputs 0, FSM IDLE; re-lock at the same delay after re-enable.

Source files
------------

// File: rtl/ber_checker_pkg.sv
// Shared comm-system constants for the BER checker: FSM encoding and the
// default PRBS period / error threshold.
package ber_checker_pkg;
   localparam int PRBS_LEN_DEF = 511;
   localparam int ERR_THR_DEF  = 0;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SEARCH = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;
endpackage

// File: rtl/ber_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones
// instead of wrapping.
module sat_counter #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (inc && (cnt != '1))
         cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/ber_checker.sv
// Per-branch PRBS bit-error-rate checker: searches the reference delay that
// aligns with the received bits, then counts errors/bits while locked.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | disabled; counters, accumulators and outputs held cleared
// ST_SEARCH | one PRBS_LEN-valid window per candidate delay, track best
// ST_LOCKED | accumulate errors/bits at chosen delay, windowed BER flag
module ber_checker
   import ber_checker_pkg::*;
#(
   parameter int NBT_COUNT_BITS_ERR = 64,
   parameter int PRBS_LEN           = PRBS_LEN_DEF,
   parameter int ERR_THR            = ERR_THR_DEF
) (
   input  logic                          clk,
   input  logic                          i_reset,
   input  logic                          i_enable,
   input  logic                          i_valid,
   input  logic                          i_ref_bit,
   input  logic                          i_rx_bit,
   output logic [NBT_COUNT_BITS_ERR-1:0] o_accum_err,
   output logic [NBT_COUNT_BITS_ERR-1:0] o_accum_tot,
   output logic                          o_sync_done,
   output logic                          o_ber_ok,
   output logic [$clog2(PRBS_LEN)-1:0]   o_delay_sel
);
   localparam int DW = $clog2(PRBS_LEN);
   // One spare bit so an all-error window still compares below best_err's reset value.
   localparam int EW = $clog2(PRBS_LEN + 1) + 1;
   localparam logic [DW-1:0] WIN_LAST = DW'(PRBS_LEN - 1);

   logic [PRBS_LEN-1:0] dly_line;
   logic [1:0]          state;
   logic [DW-1:0]       cand_d;
   logic [DW-1:0]       best_d;
   logic [DW-1:0]       win_cnt;
   logic [EW-1:0]       win_err;
   logic [EW-1:0]       best_err;
   logic [EW-1:0]       err_next;
   logic                tap;
   logic                mis;
   logic                win_end;
   logic                acc_clr;
   logic                acc_inc;

   assign tap      = (state == ST_LOCKED) ? dly_line[o_delay_sel] : dly_line[cand_d];
   assign mis      = i_rx_bit ^ tap;
   assign err_next = win_err + EW'(mis);
   assign win_end  = i_valid && (win_cnt == '0);

   assign o_sync_done = (state == ST_LOCKED);

   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset)
         dly_line <= '0;
      else if (i_valid)
         dly_line <= {dly_line[PRBS_LEN-2:0], i_ref_bit};
   end

   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         state       <= ST_IDLE;
         cand_d      <= '0;
         best_d      <= '0;
         win_cnt     <= WIN_LAST;
         win_err     <= '0;
         best_err    <= '1;
         o_delay_sel <= '0;
         o_ber_ok    <= 1'b0;
      end else if (!i_enable || (state == ST_IDLE)) begin
         state       <= i_enable ? ST_SEARCH : ST_IDLE;
         cand_d      <= '0;
         best_d      <= '0;
         win_cnt     <= WIN_LAST;
         win_err     <= '0;
         best_err    <= '1;
         o_delay_sel <= '0;
         o_ber_ok    <= 1'b0;
      end else if (i_valid) begin
         win_cnt <= (win_cnt == '0) ? WIN_LAST : win_cnt - 1'b1;
         win_err <= win_end ? '0 : err_next;
         if ((state == ST_SEARCH) && win_end) begin
            if (err_next < best_err) begin
               best_err <= err_next;
               best_d   <= cand_d;
            end
            if (err_next == '0) begin
               state       <= ST_LOCKED;
               o_delay_sel <= cand_d;
            end else if (cand_d == WIN_LAST) begin
               state       <= ST_LOCKED;
               o_delay_sel <= (err_next < best_err) ? cand_d : best_d;
            end else begin
               cand_d <= cand_d + 1'b1;
            end
         end else if ((state == ST_LOCKED) && win_end) begin
            o_ber_ok <= (err_next <= EW'(ERR_THR));
         end
      end
   end

   // Accumulators sit at zero outside LOCKED, so the lock-entry cycle starts them clean.
   assign acc_clr = !i_enable || (state != ST_LOCKED);
   assign acc_inc = i_valid && (state == ST_LOCKED);

   sat_counter #(.W(NBT_COUNT_BITS_ERR)) u_acc_tot (
      .clk (clk),
      .rst (i_reset),
      .clr (acc_clr),
      .inc (acc_inc),
      .cnt (o_accum_tot)
   );

   sat_counter #(.W(NBT_COUNT_BITS_ERR)) u_acc_err (
      .clk (clk),
      .rst (i_reset),
      .clr (acc_clr),
      .inc (acc_inc && mis),
      .cnt (o_accum_err)
   );
endmodule

// File: tb/tb_ber_checker.sv
// Directed bench for ber_checker with a 31-bit PRBS5 period and 8-bit
// accumulators: early lock, error injection, saturation, enable/reset, full search.
module tb_ber_checker;
   localparam int PL = 31;
   localparam int NB = 8;

   logic          clk = 1'b0;
   logic          i_reset = 1'b1;
   logic          i_enable = 1'b0;
   logic          i_valid = 1'b0;
   logic          i_ref_bit = 1'b0;
   logic          i_rx_bit = 1'b0;
   logic [NB-1:0] o_accum_err;
   logic [NB-1:0] o_accum_tot;
   logic          o_sync_done;
   logic          o_ber_ok;
   logic [4:0]    o_delay_sel;

   int   total = 0;
   int   bad = 0;
   int   gcnt = 0;
   int   dly_n = 6;
   logic hist [4096];
   logic [4:0] lfsr = 5'h1F;

   ber_checker #(.NBT_COUNT_BITS_ERR(NB), .PRBS_LEN(PL), .ERR_THR(0)) dut (
      .clk         (clk),
      .i_reset     (i_reset),
      .i_enable    (i_enable),
      .i_valid     (i_valid),
      .i_ref_bit   (i_ref_bit),
      .i_rx_bit    (i_rx_bit),
      .o_accum_err (o_accum_err),
      .o_accum_tot (o_accum_tot),
      .o_sync_done (o_sync_done),
      .o_ber_ok    (o_ber_ok),
      .o_delay_sel (o_delay_sel)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // rx is the reference from dly_n valids earlier, optionally inverted.
   task automatic step(input logic v, input logic flip);
      logic r;
      logic x;
      r = lfsr[4];
      x = (gcnt >= dly_n) ? hist[gcnt - dly_n] : 1'b0;
      i_valid   = v;
      i_ref_bit = r;
      i_rx_bit  = x ^ flip;
      if (v) begin
         hist[gcnt] = r;
         gcnt++;
         lfsr = {lfsr[3:0], lfsr[4] ^ lfsr[2]};
      end
      @(negedge clk);
   endtask

   task automatic run(input int n, input logic flip);
      for (int i = 0; i < n; i++) step(1'b1, flip);
   endtask

   initial begin
      @(negedge clk);
      @(negedge clk);
      chk("rst_err",  32'(o_accum_err), 0);
      chk("rst_tot",  32'(o_accum_tot), 0);
      chk("rst_sync", 32'(o_sync_done), 0);
      chk("rst_ok",   32'(o_ber_ok), 0);
      chk("rst_sel",  32'(o_delay_sel), 0);

      // early lock at tap 5: six windows of 31 valids
      i_reset  = 1'b0;
      i_enable = 1'b1;
      step(1'b0, 1'b0);
      run(185, 1'b0);
      chk("pre_lock_sync", 32'(o_sync_done), 0);
      run(1, 1'b0);
      chk("early_sync", 32'(o_sync_done), 1);
      chk("early_sel",  32'(o_delay_sel), 5);
      chk("early_tot",  32'(o_accum_tot), 0);
      chk("early_ok0",  32'(o_ber_ok), 0);

      run(30, 1'b0);
      chk("win1_ok_pre", 32'(o_ber_ok), 0);
      run(1, 1'b0);
      chk("win1_ok",  32'(o_ber_ok), 1);
      chk("win1_tot", 32'(o_accum_tot), 31);
      chk("win1_err", 32'(o_accum_err), 0);

      run(68, 1'b0);
      run(1, 1'b1);
      chk("inj_err", 32'(o_accum_err), 1);
      chk("inj_tot", 32'(o_accum_tot), 100);
      run(23, 1'b0);
      chk("inj_ok_pre", 32'(o_ber_ok), 1);
      run(1, 1'b0);
      chk("inj_ok_bad", 32'(o_ber_ok), 0);
      run(31, 1'b0);
      chk("inj_ok_back", 32'(o_ber_ok), 1);
      chk("inj_tot2",    32'(o_accum_tot), 155);
      step(1'b0, 1'b0);
      chk("hold_tot", 32'(o_accum_tot), 155);
      chk("hold_err", 32'(o_accum_err), 1);

      run(145, 1'b0);
      chk("sat_tot",     32'(o_accum_tot), 255);
      chk("sat_tot_err", 32'(o_accum_err), 1);
      run(300, 1'b1);
      chk("sat_err",    32'(o_accum_err), 255);
      chk("sat_err_tot", 32'(o_accum_tot), 255);
      chk("sat_ok",     32'(o_ber_ok), 0);

      // enable drop while locked and valid high
      i_enable = 1'b0;
      step(1'b1, 1'b0);
      chk("dis_err",  32'(o_accum_err), 0);
      chk("dis_tot",  32'(o_accum_tot), 0);
      chk("dis_sync", 32'(o_sync_done), 0);
      chk("dis_ok",   32'(o_ber_ok), 0);
      chk("dis_sel",  32'(o_delay_sel), 0);

      // reset pulse mid-search, then fresh search re-locks at tap 5
      i_enable = 1'b1;
      step(1'b0, 1'b0);
      run(50, 1'b0);
      #2 i_reset = 1'b1;
      #1 chk("rsrch_sync", 32'(o_sync_done), 0);
      @(negedge clk);
      i_reset = 1'b0;
      step(1'b0, 1'b0);
      run(185, 1'b0);
      chk("relock_pre", 32'(o_sync_done), 0);
      run(1, 1'b0);
      chk("relock_sync", 32'(o_sync_done), 1);
      chk("relock_sel",  32'(o_delay_sel), 5);
      run(10, 1'b0);
      chk("relock_tot", 32'(o_accum_tot), 10);

      // asynchronous reset while locked, mid-cycle
      #2 i_reset = 1'b1;
      #1;
      chk("arst_sync", 32'(o_sync_done), 0);
      chk("arst_sel",  32'(o_delay_sel), 0);
      chk("arst_tot",  32'(o_accum_tot), 0);
      @(negedge clk);
      i_reset = 1'b0;

      // full search: delay 11 with one forced error per window -> tap 10
      dly_n = 11;
      step(1'b0, 1'b0);
      for (int s = 0; s < 960; s++) step(1'b1, (s % PL) == 15);
      chk("full_pre", 32'(o_sync_done), 0);
      step(1'b1, 1'b0);
      chk("full_sync", 32'(o_sync_done), 1);
      chk("full_sel",  32'(o_delay_sel), 10);
      chk("full_tot0", 32'(o_accum_tot), 0);
      run(31, 1'b0);
      chk("full_ok",  32'(o_ber_ok), 1);
      chk("full_err", 32'(o_accum_err), 0);
      chk("full_tot", 32'(o_accum_tot), 31);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
